// File: rtl/cmp_pkg.sv
// Shared constants for the pipelined magnitude compare: slice width and
// bit positions of the compare flags in the ALU flag register.
package cmp_pkg;

    localparam int SLICE_W = 2;

    localparam int FLG_GE = 0;
    localparam int FLG_GT = 1;
    localparam int FLG_EQ = 2;
    localparam int FLG_LT = 3;
    localparam int FLG_W  = 4;

    typedef logic [FLG_W-1:0] flags_t;

endpackage

// File: rtl/cmp2_slice.sv
// 2-bit unsigned magnitude compare slice, purely combinational.
// Feeds the per-slice gt/eq registers of the compare pipeline.
module cmp2_slice
    import cmp_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    output logic               gt,
    output logic               eq
);

    logic hi_eq_s;

    assign hi_eq_s = ~(a[1] ^ b[1]);
    // Upper bit decides unless equal, then the lower bit decides.
    assign gt = (a[1] & ~b[1]) | (hi_eq_s & a[0] & ~b[0]);
    assign eq = hi_eq_s & ~(a[0] ^ b[0]);

endmodule

// File: rtl/cmp6_pipe.sv
// Two-stage valid/ready pipelined unsigned compare producing ge/gt/eq/lt.
// S1 captures operands, S2 holds per-slice gt/eq; flags are combined from S2.
module cmp6_pipe
    import cmp_pkg::*;
#(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_ge,
    output logic         out_gt,
    output logic         out_eq,
    output logic         out_lt
);

    localparam int NSLICE = W / SLICE_W;

    logic              v1_r;
    logic              v2_r;
    logic [W-1:0]      a1_r;
    logic [W-1:0]      b1_r;
    logic [NSLICE-1:0] gt_s;
    logic [NSLICE-1:0] eq_s;
    logic [NSLICE-1:0] gt2_r;
    logic [NSLICE-1:0] eq2_r;
    logic              rdy1_s;
    logic              rdy2_s;
    logic              gt_all_s;
    logic              eq_all_s;
    flags_t            flags_s;

    // Ready depends only on stage occupancy and out_ready, never on in_valid.
    assign rdy2_s   = ~v2_r | out_ready;
    assign rdy1_s   = ~v1_r | rdy2_s;
    assign in_ready = rdy1_s;

    for (genvar k = 0; k < NSLICE; k++) begin : g_slice
        cmp2_slice u_slice (
            .a  (a1_r[SLICE_W*k +: SLICE_W]),
            .b  (b1_r[SLICE_W*k +: SLICE_W]),
            .gt (gt_s[k]),
            .eq (eq_s[k])
        );
    end

    // S1 operand register: loads on input transfer, empties when it advances.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_r <= 1'b0;
            a1_r <= '0;
            b1_r <= '0;
        end else if (rdy1_s) begin
            v1_r <= in_valid;
            if (in_valid) begin
                a1_r <= a;
                b1_r <= b;
            end
        end
    end

    // S2 slice-result register: advances whenever the consumer side has room.
    always_ff @(posedge clk) begin
        if (reset) begin
            v2_r  <= 1'b0;
            gt2_r <= '0;
            eq2_r <= '0;
        end else if (rdy2_s) begin
            v2_r <= v1_r;
            if (v1_r) begin
                gt2_r <= gt_s;
                eq2_r <= eq_s;
            end
        end
    end

    // Combine slices from the most significant end; a lower slice only counts
    // while every slice above it compares equal.
    always_comb begin
        gt_all_s = 1'b0;
        eq_all_s = 1'b1;
        for (int k = NSLICE - 1; k >= 0; k--) begin
            gt_all_s = gt_all_s | (gt2_r[k] & eq_all_s);
            eq_all_s = eq_all_s & eq2_r[k];
        end
    end

    // Flags are only meaningful alongside out_valid; hold them low otherwise.
    always_comb begin
        flags_s = '0;
        if (v2_r) begin
            flags_s[FLG_GT] = gt_all_s;
            flags_s[FLG_EQ] = eq_all_s;
            flags_s[FLG_GE] = gt_all_s | eq_all_s;
            flags_s[FLG_LT] = ~(gt_all_s | eq_all_s);
        end else begin
            flags_s = '0;
        end
    end

    assign out_valid = v2_r;
    assign out_ge    = flags_s[FLG_GE];
    assign out_gt    = flags_s[FLG_GT];
    assign out_eq    = flags_s[FLG_EQ];
    assign out_lt    = flags_s[FLG_LT];

endmodule

// File: tb/tb_cmp6_pipe.sv
// Self-checking bench for cmp6_pipe: directed latency/stall/reset scenarios
// plus a randomized stream checked against an arithmetic reference queue.
module tb_cmp6_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [5:0] a, b;
    logic       out_ge, out_gt, out_eq, out_lt;

    logic       in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0] a8, b8;
    logic       out_ge8, out_gt8, out_eq8, out_lt8;

    int tests = 0;
    int fails = 0;

    cmp6_pipe #(.W(6)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .out_ge(out_ge), .out_gt(out_gt), .out_eq(out_eq), .out_lt(out_lt)
    );

    cmp6_pipe #(.W(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
        .out_ge(out_ge8), .out_gt(out_gt8), .out_eq(out_eq8), .out_lt(out_lt8)
    );

    always #5 clk = ~clk;

    // Reference: flags as {lt, eq, gt, ge} from plain unsigned arithmetic.
    function automatic logic [3:0] ref_flags(input int unsigned x, input int unsigned y);
        logic [3:0] r;
        r[0] = (x >= y);
        r[1] = (x >  y);
        r[2] = (x == y);
        r[3] = (x <  y);
        return r;
    endfunction

    function automatic logic [3:0] flags6();
        return {out_lt, out_eq, out_gt, out_ge};
    endfunction

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = 6'd0; b = 6'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if ({out_valid, flags6(), in_ready} !== 6'b000001) begin
            fails++;
            $display("FAIL reset_state: valid/flags/ready=%b expected 000001",
                     {out_valid, flags6(), in_ready});
        end
    endtask

    task automatic test_single();
        in_valid = 1'b1; a = 6'd45; b = 6'd45; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL single_lat1: out_valid=%b expected 0", out_valid);
        end
        @(negedge clk); #1;
        tests++;
        if ({out_valid, flags6()} !== {1'b1, 4'b0101}) begin
            fails++; $display("FAIL single_eq: valid,flags=%b expected 10101", {out_valid, flags6()});
        end
        @(negedge clk); #1;
        tests++;
        if ({out_valid, flags6()} !== 5'b00000) begin
            fails++; $display("FAIL single_once: valid,flags=%b expected 00000", {out_valid, flags6()});
        end
    endtask

    task automatic test_back_to_back();
        int pa[5] = '{63, 0, 36, 35, 16};
        int pb[5] = '{0, 63, 35, 36, 16};
        out_ready = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 7; c++) begin
            if (c < 5) begin
                in_valid = 1'b1; a = 6'(pa[c]); b = 6'(pb[c]);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c < 5) begin
                tests++;
                if (in_ready !== 1'b1) begin
                    fails++; $display("FAIL b2b_ready c=%0d: in_ready=%b expected 1", c, in_ready);
                end
            end
            if (c >= 2) begin
                tests++;
                if ({out_valid, flags6()} !== {1'b1, ref_flags(pa[c-2], pb[c-2])}) begin
                    fails++;
                    $display("FAIL b2b_flags c=%0d: valid,flags=%b expected %b", c,
                             {out_valid, flags6()}, {1'b1, ref_flags(pa[c-2], pb[c-2])});
                end
            end
            @(negedge clk);
        end
        #1;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL b2b_drain: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b1;
        in_valid = 1'b1; a = 6'd20; b = 6'd21;
        @(negedge clk);
        a = 6'd21; b = 6'd20;
        @(negedge clk);
        out_ready = 1'b0; a = 6'd10; b = 6'd10;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if ({in_ready, out_valid, flags6()} !== {1'b0, 1'b1, ref_flags(20, 21)}) begin
                fails++;
                $display("FAIL stall_hold i=%0d: ready,valid,flags=%b expected %b", i,
                         {in_ready, out_valid, flags6()}, {1'b0, 1'b1, ref_flags(20, 21)});
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL stall_release_ready: in_ready=%b expected 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        tests++;
        if ({out_valid, flags6()} !== {1'b1, ref_flags(21, 20)}) begin
            fails++; $display("FAIL stall_second: valid,flags=%b expected %b",
                              {out_valid, flags6()}, {1'b1, ref_flags(21, 20)});
        end
        @(negedge clk); #1;
        tests++;
        if ({out_valid, flags6()} !== {1'b1, ref_flags(10, 10)}) begin
            fails++; $display("FAIL stall_held_input: valid,flags=%b expected %b",
                              {out_valid, flags6()}, {1'b1, ref_flags(10, 10)});
        end
        @(negedge clk); #1;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL stall_no_dup: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        in_valid = 1'b1; a = 6'd7; b = 6'd3;
        @(negedge clk);
        in_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        // Second case: reset and in_valid together; reset must win.
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if ({out_valid, flags6(), in_ready} !== 6'b000001) begin
                fails++; $display("FAIL reset_mid i=%0d: valid/flags/ready=%b expected 000001",
                                  i, {out_valid, flags6(), in_ready});
            end
            if (i == 0) begin
                reset = 1'b1; in_valid = 1'b1; a = 6'd9; b = 6'd1;
            end else begin
                reset = 1'b0; in_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_boundary();
        out_ready = 1'b1; out_ready8 = 1'b1;
        in_valid = 1'b1; a = 6'b010000; b = 6'b001111;
        in_valid8 = 1'b1; a8 = 8'd255; b8 = 8'd254;
        @(negedge clk);
        a = 6'b110011; b = 6'b110100; in_valid8 = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        tests++;
        if ({out_valid, flags6()} !== {1'b1, 4'b0011}) begin
            fails++; $display("FAIL bnd_gt6: valid,flags=%b expected 10011", {out_valid, flags6()});
        end
        tests++;
        if ({out_valid8, out_lt8, out_eq8, out_gt8, out_ge8} !== {1'b1, ref_flags(255, 254)}) begin
            fails++; $display("FAIL bnd_gt8: valid,flags=%b expected %b",
                              {out_valid8, out_lt8, out_eq8, out_gt8, out_ge8}, {1'b1, ref_flags(255, 254)});
        end
        @(negedge clk); #1;
        tests++;
        if ({out_valid, flags6()} !== {1'b1, 4'b1000}) begin
            fails++; $display("FAIL bnd_lt6: valid,flags=%b expected 11000", {out_valid, flags6()});
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [3:0] exp_q[$];
        logic [3:0] exp;
        int         budget;
        in_valid = 1'b0;
        for (int c = 0; c < 300; c++) begin
            // A presented input stays put until it is accepted.
            if (!in_valid || in_ready) begin
                in_valid = ($urandom_range(3) != 0);
                a = 6'($urandom);
                b = ($urandom_range(3) == 0) ? a : 6'($urandom);
            end
            out_ready = ($urandom_range(2) != 0);
            #1;
            tests++;
            if (in_ready !== ((exp_q.size() < 2) || out_ready)) begin
                fails++; $display("FAIL rnd_ready c=%0d: in_ready=%b inflight=%0d out_ready=%b",
                                  c, in_ready, exp_q.size(), out_ready);
            end
            if (!out_valid) begin
                tests++;
                if (flags6() !== 4'b0000) begin
                    fails++; $display("FAIL rnd_idle_flags c=%0d: flags=%b expected 0000", c, flags6());
                end
            end else if (out_ready) begin
                tests++;
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
                if (flags6() !== exp) begin
                    fails++; $display("FAIL rnd_flags c=%0d: flags=%b expected %b", c, flags6(), exp);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_flags(a, b));
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            #1;
            if (out_valid) begin
                tests++;
                exp = exp_q.pop_front();
                if (flags6() !== exp) begin
                    fails++; $display("FAIL rnd_drain: flags=%b expected %b", flags6(), exp);
                end
            end
            budget++;
            @(negedge clk);
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL rnd_lost: %0d results never emitted, expected 0", exp_q.size());
        end
    endtask

    initial begin
        in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = 8'd0; b8 = 8'd0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_boundary();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
